frame_buffer_ctrl: RTL
======================

# frame_buffer_ctrl

Triple-buffer ownership controller for the DDR frame store shared by the camera-side AXI4 writer and the HDMI-side AXI4 reader. It tracks which of three frame buffers is being written, which holds the latest complete frame, and which is being displayed. It hands each side a stable base address and swaps ownership on writer-done and display-vsync events. It replaces ad-hoc buffer-select toggling and runs entirely in the 100 MHz AXI domain.

## Interface
- BASE_ADDR, 32'h1000_0000: DDR address of buffer 0.
- FRAME_STRIDE, 32'h0010_0000: byte distance between buffers; must be ≥ 640·480·2.
- clk_100Mhz  in  1  AXI clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- ctrl_en  in  1  high = process events; low = ignore new edges, hold state.
- writer_done  in  1  level/pulse from the writer, already in clk_100Mhz; rising edge = frame complete.
- vsync_sync2  in  1  display frame start, already synchronised to clk_100Mhz; rising edge = reader frame boundary.
- wr_base_addr  out  32  base address the writer uses for its next frame.
- rd_base_addr  out  32  base address the reader uses for the current frame.
- wr_buf_idx, rd_buf_idx  out  2 each  buffer indices, 0..2.
- rd_frame_valid  out  1  0 until the first completed frame is displayed.
- swap_pulse  out  1  one-cycle strobe when rd_buf_idx changes.
- frames_written, frames_dropped, frames_repeated  out  16 each  statistics counters.

## Operation
- Per-input edge detect: prev register; edge = in & ~prev & ctrl_en. A held-high input counts once. prev updates even when ctrl_en=0.
- State: disp (reader index), wr (writer index), rdy (latest-complete index), rdy_valid. Invariant: disp ≠ wr; when rdy_valid=1, all three are distinct. spare = 3 − disp − wr.
- Phases: EMPTY (rd_frame_valid=0, no frame shown yet) and RUN. EMPTY → RUN on the first vsync edge with rdy_valid=1. No path back except reset.
- wr edge:
  - rdy ← wr, rdy_valid ← 1.
  - wr ← old rdy if old rdy_valid, else spare.
  - frames_written +1. frames_dropped +1 if an old rdy was overwritten.
- vsync edge:
  - If rdy_valid: disp ← rdy, rdy_valid ← 0, swap_pulse=1.
  - Else: disp unchanged; frames_repeated +1, counted only in RUN.
- Both edges in the same cycle: apply wr first, then vsync on the updated state. Result: disp = old wr, wr = old rdy (or spare), rdy_valid=0, one swap_pulse.
- Addresses: BASE_ADDR + idx·FRAME_STRIDE as 32-bit wrap-around adds, registered from the index next-state.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - disp=0, wr=1, rdy_valid=0, phase EMPTY.
  - rd_buf_idx=0, wr_buf_idx=1, rd_base_addr=BASE_ADDR, wr_base_addr=BASE_ADDR+FRAME_STRIDE.
  - rd_frame_valid=0, swap_pulse=0, all counters 0, prev registers 0.
- Latency: input high at rising edge k (low at k−1) → all outputs reflect the event after edge k, i.e. one cycle.
- The writer samples wr_base_addr at its own frame start. The value is stable from one cycle after writer_done until the next writer_done.
- rd_base_addr changes only on a vsync edge, so it is stable for the whole display frame.
- Reset asserted mid-operation returns to the reset values immediately and asynchronously. Release is synchronised by the rest of the system.

## Configuration
- FB_STATS_EN defined: the three counters are implemented as specified.
- FB_STATS_EN undefined: frames_written, frames_dropped and frames_repeated are tied to 16'h0 and no counter registers exist. Buffer behaviour is identical in both cases.

## Structure
- Package fb_ctrl_pkg holds:
  - buf_idx_t (2-bit).
  - NUM_BUF=3, RST_DISP_IDX=0, RST_WR_IDX=1.
  - the phase enum {EMPTY, RUN}.
  - a spare-index function.
- One sub-module, rise_edge_det (prev register, ctrl_en gating), instantiated twice.

## Test plan
- Reset release, no events → rd_buf_idx=0, wr_buf_idx=1, wr_base_addr=32'h1010_0000, rd_frame_valid=0.
- One writer_done, then vsync → after writer_done: wr_buf_idx=2. After vsync: rd_buf_idx=1, swap_pulse for one cycle, rd_frame_valid=1, rd_base_addr=32'h1010_0000.
- Three writer_done edges with no vsync → frames_written=3, frames_dropped=2, indices always distinct, rd_buf_idx stays 0.
- In RUN, vsync with rdy_valid=0 → rd_buf_idx unchanged, frames_repeated +1, no swap_pulse.
- writer_done and vsync rising in the same cycle (state disp=0, wr=1, no rdy) → rd_buf_idx=1, wr_buf_idx=2, rdy_valid=0, one swap_pulse.
- ctrl_en=0 during an edge, and writer_done held high for 10 cycles → no state change for the gated edge. The held pulse counts once. Asserting sys_rst_n low mid-sequence restores the reset values within the same cycle.

Source files
------------

// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the triple-buffer frame store controller.
package fb_ctrl_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int       NUM_BUF      = 3;
  localparam buf_idx_t RST_DISP_IDX = 2'd0;
  localparam buf_idx_t RST_WR_IDX   = 2'd1;
  localparam buf_idx_t RST_RDY_IDX  = 2'd2;

  typedef enum logic {EMPTY, RUN} phase_t;

  // The three indices sum to 0+1+2, so the free buffer is 3 - a - b.
  function automatic buf_idx_t spare_idx(buf_idx_t a, buf_idx_t b);
    return buf_idx_t'(NUM_BUF) - a - b;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector with enable gating; history tracks the input even when gated.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= din;
  end

  assign rise = din & ~prev & en;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Triple-buffer ownership controller: writer / latest-complete / display rotation.
// Optional statistics counters are built only when FB_STATS_EN is defined.
module frame_buffer_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0010_0000
) (
  input  logic        clk_100Mhz,
  input  logic        sys_rst_n,
  input  logic        ctrl_en,
  input  logic        writer_done,
  input  logic        vsync_sync2,
  output logic [31:0] wr_base_addr,
  output logic [31:0] rd_base_addr,
  output logic [1:0]  wr_buf_idx,
  output logic [1:0]  rd_buf_idx,
  output logic        rd_frame_valid,
  output logic        swap_pulse,
  output logic [15:0] frames_written,
  output logic [15:0] frames_dropped,
  output logic [15:0] frames_repeated
);

  function automatic logic [31:0] buf_addr(buf_idx_t i);
    return BASE_ADDR + FRAME_STRIDE * {30'd0, i};
  endfunction

  logic wr_edge, vs_edge;

  rise_edge_det u_wr_det (
    .clk(clk_100Mhz), .rst_n(sys_rst_n), .en(ctrl_en), .din(writer_done), .rise(wr_edge)
  );

  rise_edge_det u_vs_det (
    .clk(clk_100Mhz), .rst_n(sys_rst_n), .en(ctrl_en), .din(vsync_sync2), .rise(vs_edge)
  );

  buf_idx_t disp, wr, rdy;
  logic     rdy_valid;
  phase_t   phase;

  buf_idx_t n_disp, n_wr, n_rdy;
  logic     n_rdy_valid, n_swap, n_drop, n_repeat;

  // Writer edge is applied first so a coincident vsync sees the fresh frame.
  always_comb begin
    n_disp      = disp;
    n_wr        = wr;
    n_rdy       = rdy;
    n_rdy_valid = rdy_valid;
    n_swap      = 1'b0;
    n_drop      = 1'b0;
    n_repeat    = 1'b0;
    if (wr_edge) begin
      n_rdy       = wr;
      n_rdy_valid = 1'b1;
      n_wr        = rdy_valid ? rdy : spare_idx(disp, wr);
      n_drop      = rdy_valid;
    end
    if (vs_edge) begin
      if (n_rdy_valid) begin
        n_disp      = n_rdy;
        n_rdy_valid = 1'b0;
        n_swap      = 1'b1;
      end else begin
        n_repeat = (phase == RUN);
      end
    end
  end

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp         <= RST_DISP_IDX;
      wr           <= RST_WR_IDX;
      rdy          <= RST_RDY_IDX;
      rdy_valid    <= 1'b0;
      phase        <= EMPTY;
      swap_pulse   <= 1'b0;
      rd_base_addr <= buf_addr(RST_DISP_IDX);
      wr_base_addr <= buf_addr(RST_WR_IDX);
    end else begin
      disp         <= n_disp;
      wr           <= n_wr;
      rdy          <= n_rdy;
      rdy_valid    <= n_rdy_valid;
      swap_pulse   <= n_swap;
      rd_base_addr <= buf_addr(n_disp);
      wr_base_addr <= buf_addr(n_wr);
      // A swap only happens with a ready frame, which is exactly the EMPTY exit.
      case (phase)
        EMPTY:   if (n_swap) phase <= RUN;
        default: phase <= RUN;
      endcase
    end
  end

  assign rd_buf_idx     = disp;
  assign wr_buf_idx     = wr;
  assign rd_frame_valid = (phase == RUN);

`ifdef FB_STATS_EN
  logic [15:0] cnt_wr, cnt_drop, cnt_rep;

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_wr   <= 16'h0;
      cnt_drop <= 16'h0;
      cnt_rep  <= 16'h0;
    end else begin
      if (wr_edge  && cnt_wr   != 16'hFFFF) cnt_wr   <= cnt_wr + 16'd1;
      if (n_drop   && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
      if (n_repeat && cnt_rep  != 16'hFFFF) cnt_rep  <= cnt_rep + 16'd1;
    end
  end

  assign frames_written  = cnt_wr;
  assign frames_dropped  = cnt_drop;
  assign frames_repeated = cnt_rep;
`else
  assign frames_written  = 16'h0;
  assign frames_dropped  = 16'h0;
  assign frames_repeated = 16'h0;
`endif

endmodule
